// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join sequencer: controller states and join modes.
package fork_join_pkg;

  localparam int unsigned FJ_ST_W = 3;

  typedef enum logic [FJ_ST_W-1:0] {
    IDLE  = 3'd0,
    FORK  = 3'd1,
    WAIT  = 3'd2,
    POST  = 3'd3,
    WPOST = 3'd4,
    DONE  = 3'd5
  } fj_state_e;

  typedef enum logic {
    JOIN_ALL = 1'b0,
    JOIN_ANY = 1'b1
  } fj_mode_e;

  // States in which branch completion pulses are recorded.
  function automatic logic fj_capture_state(input fj_state_e s);
    return (s == FORK) || (s == WAIT) || (s == POST) || (s == WPOST);
  endfunction

endpackage

// File: rtl/fj_first_pick.sv
// Lowest-index priority encoder: picks the first set request bit and flags
// whether any bit is set.
module fj_first_pick #(
  parameter  int unsigned N    = 2,
  localparam int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  output logic [ID_W-1:0] idx_c,
  output logic            valid_c
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx_c   = '0;
    valid_c = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_c   = ID_W'(i);
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join sequencer: launches N_BR branches, joins on all/any, then runs a
// post job. Optional WAIT timeout is built when FJ_TIMEOUT_EN is defined.
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter  int unsigned N_BR    = 2,
  parameter  int unsigned CNT_W   = 16,
  parameter  int unsigned TMO_CYC = 1000,
  localparam int unsigned ID_W    = $clog2(N_BR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  output logic [N_BR-1:0]  br_start,
  input  logic [N_BR-1:0]  br_done,
  output logic             post_start,
  input  logic             post_done,
  output logic             busy,
  output logic [ID_W-1:0]  first_id,
  output logic [N_BR-1:0]  done_mask,
  output logic [CNT_W-1:0] elapsed,
`ifdef FJ_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic             cmp_valid
);

  if (N_BR < 2 || N_BR > 8 || TMO_CYC == 0) begin : g_cfg_err
    $error("fork_join_ctrl: unsupported parameter set");
  end

`ifdef FJ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
`endif

  fj_state_e        state_q, state_d;
  fj_mode_e         mode_q, mode_d;
  logic [N_BR-1:0]  done_mask_q, done_mask_d;
  logic [ID_W-1:0]  first_id_q, first_id_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic             post_seen_q, post_seen_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [N_BR-1:0]  br_start_q, br_start_d;
  logic             post_start_q, post_start_d;
  logic             busy_q, busy_d;
  logic             cmp_valid_q, cmp_valid_d;
`ifdef FJ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  logic [N_BR-1:0]  mask_cap_c;
  logic [ID_W-1:0]  pick_idx_c;
  logic             pick_valid_c;
  logic             join_hit_c;
  logic             all_done_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Done mask including this cycle's pulses; join decisions look at this.
  assign mask_cap_c = fj_capture_state(state_q) ? (done_mask_q | br_done) : done_mask_q;
  assign all_done_c = &mask_cap_c;
  assign join_hit_c = (mode_q == JOIN_ALL) ? all_done_c : (|mask_cap_c);

  fj_first_pick #(.N(N_BR)) u_first_pick (
    .req     (mask_cap_c),
    .idx_c   (pick_idx_c),
    .valid_c (pick_valid_c)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    done_mask_d = mask_cap_c;
    first_id_d  = first_id_q;
    elapsed_d   = elapsed_q;
    post_seen_d = post_seen_q;
`ifdef FJ_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = timeout_q;
`endif

    // Latch the winner only on the cycle the mask leaves zero.
    if ((done_mask_q == '0) && pick_valid_c) begin
      first_id_d = pick_idx_c;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d     = FORK;
          mode_d      = fj_mode_e'(cmd_mode);
          done_mask_d = '0;
          first_id_d  = '0;
          elapsed_d   = '0;
          post_seen_d = 1'b0;
`ifdef FJ_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
        end
      end
      FORK: begin
        elapsed_d = sat_inc(elapsed_q);
        state_d   = WAIT;
`ifdef FJ_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      WAIT: begin
        elapsed_d = sat_inc(elapsed_q);
        if (join_hit_c) begin
          state_d = POST;
        end
`ifdef FJ_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      POST: begin
        state_d = WPOST;
      end
      WPOST: begin
        // Hold here until the post job and every branch have reported.
        if (post_done) begin
          post_seen_d = 1'b1;
        end
        if ((post_seen_q || post_done) && all_done_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d  = (state_d == IDLE);
    br_start_d   = {N_BR{state_d == FORK}};
    post_start_d = (state_d == POST);
    busy_d       = (state_d != IDLE);
    cmp_valid_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= JOIN_ALL;
      done_mask_q  <= '0;
      first_id_q   <= '0;
      elapsed_q    <= '0;
      post_seen_q  <= 1'b0;
      cmd_ready_q  <= 1'b1;
      br_start_q   <= '0;
      post_start_q <= 1'b0;
      busy_q       <= 1'b0;
      cmp_valid_q  <= 1'b0;
`ifdef FJ_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      done_mask_q  <= done_mask_d;
      first_id_q   <= first_id_d;
      elapsed_q    <= elapsed_d;
      post_seen_q  <= post_seen_d;
      cmd_ready_q  <= cmd_ready_d;
      br_start_q   <= br_start_d;
      post_start_q <= post_start_d;
      busy_q       <= busy_d;
      cmp_valid_q  <= cmp_valid_d;
`ifdef FJ_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign br_start   = br_start_q;
  assign post_start = post_start_q;
  assign busy       = busy_q;
  assign first_id   = first_id_q;
  assign done_mask  = done_mask_q;
  assign elapsed    = elapsed_q;
  assign cmp_valid  = cmp_valid_q;
`ifdef FJ_TIMEOUT_EN
  assign timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Scoreboarded bench for fork_join_ctrl: directed scenarios plus random
// fork/join transactions checked against a timing-rule reference model.
module tb_fork_join_ctrl;

  localparam int unsigned N_BR  = 2;
  localparam int unsigned CNT_W = 16;
`ifdef FJ_TIMEOUT_EN
  localparam int unsigned TMO_CYC = 50;
`else
  localparam int unsigned TMO_CYC = 1000;
`endif

  typedef int br_arr_t [N_BR];
  typedef struct {
    int post_off;
    int cmp_off;
    int elapsed;
    int first_id;
    int mask;
    int tmo;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_mode = 1'b0;
  logic [N_BR-1:0]  br_start;
  logic [N_BR-1:0]  br_done = '0;
  logic             post_start;
  logic             post_done = 1'b0;
  logic             busy;
  logic [0:0]       first_id;
  logic [N_BR-1:0]  done_mask;
  logic [CNT_W-1:0] elapsed;
  logic             cmp_valid;
  logic             timeout;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  fork_join_ctrl #(.N_BR(N_BR), .CNT_W(CNT_W), .TMO_CYC(TMO_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .br_start   (br_start),
    .br_done    (br_done),
    .post_start (post_start),
    .post_done  (post_done),
    .busy       (busy),
    .first_id   (first_id),
    .done_mask  (done_mask),
    .elapsed    (elapsed),
`ifdef FJ_TIMEOUT_EN
    .timeout    (timeout),
`endif
    .cmp_valid  (cmp_valid)
  );

`ifndef FJ_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: offsets are cycles after the FORK cycle (FORK = 0).
  function automatic exp_t model(input bit mode, input br_arr_t d, input int posts[$]);
    exp_t e;
    int   mn = 1 << 30;
    int   mx = -1;
    int   pv = 1 << 30;
    int   tj;
    e.first_id = 0;
    for (int i = 0; i < N_BR; i++) begin
      if (d[i] >= 0) begin
        if (d[i] < mn) begin
          mn = d[i];
          e.first_id = i;
        end
        if (d[i] > mx) mx = d[i];
      end
    end
    if (mx < 0) begin
      e.tmo      = 1;
      e.post_off = -1;
      e.cmp_off  = TMO_CYC + 1;
      e.elapsed  = TMO_CYC + 1;
      e.mask     = 0;
      return e;
    end
    tj = mode ? mn : mx;
    if (tj < 1) tj = 1;
    e.tmo      = 0;
    e.elapsed  = tj + 1;
    e.post_off = tj + 1;
    foreach (posts[k]) if (posts[k] >= tj + 2 && posts[k] < pv) pv = posts[k];
    e.cmp_off = ((pv > mx) ? pv : mx) + 1;
    e.mask    = (1 << N_BR) - 1;
    return e;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_br_start"}, int'(br_start), 0);
    check({tag, "_post_start"}, int'(post_start), 0);
    check({tag, "_cmp_valid"}, int'(cmp_valid), 0);
    check({tag, "_done_mask"}, int'(done_mask), 0);
    check({tag, "_elapsed"}, int'(elapsed), 0);
    check({tag, "_first_id"}, int'(first_id), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
  endtask

  // Driver: runs one command whose pulses are scheduled relative to FORK.
  task automatic run_txn(input bit mode, input br_arr_t d, input br_arr_t rep,
                         input int posts[$], input int rst_at);
    exp_t e;
    int   n_wait = 0;
    int   last;
    while (!cmd_ready && n_wait < 300) begin
      @(posedge clk); #1;
      n_wait++;
    end
    if (!cmd_ready) begin
      check("idle_wait", int'(cmd_ready), 1);
      return;
    end
    // Noise while idle must be ignored.
    br_done   = N_BR'($urandom);
    post_done = 1'($urandom);
    @(posedge clk); #1;
    br_done   = '0;
    post_done = 1'b0;
    e = model(mode, d, posts);
    if (rst_at < 0) sb_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_mode  = 1'($urandom);
    last = (rst_at >= 0) ? rst_at : e.cmp_off;
    for (int k = 0; k <= last; k++) begin
      br_done   = '0;
      post_done = 1'b0;
      for (int i = 0; i < N_BR; i++) if (d[i] == k || rep[i] == k) br_done[i] = 1'b1;
      foreach (posts[j]) if (posts[j] == k) post_done = 1'b1;
      rst = (k == rst_at);
      @(posedge clk); #1;
    end
    br_done   = '0;
    post_done = 1'b0;
    rst       = 1'b0;
    if (rst_at >= 0) check_idle_outputs("midrst");
  endtask

  task automatic directed(input bit mode, input int d0, input int d1,
                          input int p0, input int p1, input int rst_at);
    br_arr_t d;
    br_arr_t rep;
    int      pq[$];
    d[0] = d0;
    d[1] = d1;
    rep[0] = -1;
    rep[1] = -1;
    if (p0 >= 0) pq.push_back(p0);
    if (p1 >= 0) pq.push_back(p1);
    run_txn(mode, d, rep, pq, rst_at);
  endtask

  task automatic random_txn();
    br_arr_t d;
    br_arr_t rep;
    int      pq[$];
    bit      mode;
    int      mn = 1 << 30;
    int      mx = -1;
    int      tj;
    mode = 1'($urandom);
    for (int i = 0; i < N_BR; i++) begin
      d[i] = int'($urandom_range(0, 25));
      if (d[i] < mn) mn = d[i];
      if (d[i] > mx) mx = d[i];
    end
    for (int i = 0; i < N_BR; i++) begin
      rep[i] = -1;
      if (d[i] < mx && $urandom_range(0, 1) == 1) rep[i] = int'($urandom_range(d[i] + 1, mx));
    end
    tj = mode ? mn : mx;
    if (tj < 1) tj = 1;
    if ($urandom_range(0, 1) == 1) pq.push_back(int'($urandom_range(0, tj)));
    pq.push_back(tj + 2 + int'($urandom_range(0, 10)));
    run_txn(mode, d, rep, pq, -1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports an event.
  initial begin
    int   cyc = 0;
    int   fork_cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (br_start != '0) begin
        check("br_start_all", int'(br_start), (1 << N_BR) - 1);
        fork_cyc = cyc;
      end
      if (post_start === 1'b1) begin
        if (sb_q.size() == 0) check("post_unexpected", 1, 0);
        else check("post_offset", cyc - fork_cyc, sb_q[0].post_off);
      end
      if (cmp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("cmp_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("cmp_offset", cyc - fork_cyc, e.cmp_off);
          check("elapsed", int'(elapsed), e.elapsed);
          check("first_id", int'(first_id), e.first_id);
          check("done_mask", int'(done_mask), e.mask);
          check("timeout", int'(timeout), e.tmo);
          check("cmd_ready_in_done", int'(cmd_ready), 0);
          check("busy_in_done", int'(busy), 1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t reached limit, pending=%0d", $time, sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    directed(1'b1, 10, 20, 40, -1, -1);
    directed(1'b0, 10, 20, 40, -1, -1);
    directed(1'b1, 3, 3, 10, -1, -1);
    directed(1'b1, 5, 20, 8, -1, -1);
    directed(1'b1, 30, 30, -1, -1, 7);
    directed(1'b0, 2, 4, 7, -1, -1);
    directed(1'b0, 0, 0, 1, 3, -1);
    directed(1'b1, 6, 0, 4, 9, -1);
`ifdef FJ_TIMEOUT_EN
    directed(1'b0, -1, -1, -1, -1, -1);
    directed(1'b1, 4, 7, 12, -1, -1);
`endif
    for (int n = 0; n < 40; n++) random_txn();
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
